// File: rtl/cnff_ctrl_pkg.sv
// Shared definitions for the cnff bank controller: opcodes, FSM states and cell behaviour.
// The CHECK state is only reachable when CNFF_CTRL_READBACK_EN is defined.
package cnff_ctrl_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_CLR = 2'b01;
   localparam logic [1:0] OP_TGL = 2'b10;
   localparam logic [1:0] OP_SET = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      EXEC1,
      EXEC2,
      CHECK,
      ACK
   } state_e;

   // One cnff cell: hold when n=0, clear when n=1/c=0, toggle when n=1/c=1.
   function automatic logic cnff_next(input logic q, input logic c, input logic n);
      return n ? (c & ~q) : q;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   pointer,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx
);

   logic [IW-1:0] sel;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      sel       = '0;
      // Walk from the farthest candidate back to the pointer so the nearest one wins.
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         sel = IW'((int'(pointer) + k) % int'(NREQ));
         if (req[sel]) begin
            grant      = '0;
            grant[sel] = 1'b1;
            grant_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/cnff_bank_ctrl.sv
// Round-robin sequencer that turns CLR/TGL/SET commands into c/n cycles for a cnff bank.
// Defining CNFF_CTRL_READBACK_EN adds a shadow bank, a CHECK state and the bank_q/err ports.
module cnff_bank_ctrl
   import cnff_ctrl_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [2*NREQ-1:0]       op,
   input  logic [WIDTH*NREQ-1:0]   mask,
   output logic [NREQ-1:0]         ack,
   output logic                    busy,
   output logic [WIDTH-1:0]        c_out,
   output logic [WIDTH-1:0]        n_out
`ifdef CNFF_CTRL_READBACK_EN
   ,
   input  logic [WIDTH-1:0]        bank_q,
   output logic                    err
`endif
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef CNFF_CTRL_READBACK_EN
   localparam state_e POST_EXEC = CHECK;
`else
   localparam state_e POST_EXEC = ACK;
`endif

   state_e           state_q, state_d;
   logic [NREQ-1:0]  grant;
   logic [IW-1:0]    grant_idx;
   logic [IW-1:0]    ptr_q, win_q;
   logic [1:0]       op_q, op_sel, op_cur;
   logic [WIDTH-1:0] mask_q, mask_sel, mask_cur;
   logic [WIDTH-1:0] c_d, n_d;
   logic [NREQ-1:0]  ack_d;
   logic             start;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .req      (req),
      .pointer  (ptr_q),
      .grant    (grant),
      .grant_idx(grant_idx)
   );

   assign start = (state_q == IDLE) && (|req);
   assign busy  = (state_q != IDLE);

   always_comb begin
      op_sel   = '0;
      mask_sel = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant[i]) begin
            op_sel   = op[2*i +: 2];
            mask_sel = mask[WIDTH*i +: WIDTH];
         end
      end
   end

   // The registered outputs are loaded in the same edge that captures the command.
   assign op_cur   = start ? op_sel : op_q;
   assign mask_cur = start ? mask_sel : mask_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|req) state_d = EXEC1;
         EXEC1:   state_d = (op_q == OP_SET) ? EXEC2 : POST_EXEC;
         EXEC2:   state_d = POST_EXEC;
         CHECK:   state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      c_d   = '0;
      n_d   = '0;
      ack_d = '0;
      case (state_d)
         EXEC1: begin
            n_d = (op_cur == OP_NOP) ? '0 : mask_cur;
            c_d = (op_cur == OP_TGL) ? mask_cur : '0;
         end
         EXEC2: begin
            n_d = mask_cur;
            c_d = mask_cur;
         end
         ACK:     ack_d[win_q] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q  <= '0;
         win_q  <= '0;
         op_q   <= OP_NOP;
         mask_q <= '0;
         c_out  <= '0;
         n_out  <= '0;
         ack    <= '0;
      end else begin
         c_out <= c_d;
         n_out <= n_d;
         ack   <= ack_d;
         if (start) begin
            win_q  <= grant_idx;
            op_q   <= op_sel;
            mask_q <= mask_sel;
         end
         if (state_q == ACK) begin
            ptr_q <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
         end
      end
   end

`ifdef CNFF_CTRL_READBACK_EN
   logic [WIDTH-1:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         shadow_d[i] = cnff_next(shadow_q[i], c_out[i], n_out[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         err      <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         if ((state_q == CHECK) && (bank_q != shadow_q)) begin
            err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/cnff_bank_ctrl.md
Name: cnff_bank_ctrl

Overview:
- Sequencer and arbiter for a bank of WIDTH cnff cells. Each cell holds when n=0, clears when n=1/c=0, and toggles when n=1/c=1.
- Shares the bank between NREQ requesters using round-robin arbitration.
- Translates each granted command (CLR, TGL, SET) into per-bit c/n control cycles and returns a one-cycle ack to the winner.
- Sits between register-access logic and the cnff bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of cnff cells in the bank.

Ports:
- clk  input  1  rising-edge clock, shared with the cnff bank.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level.
- op  input  2*NREQ  per-requester opcode; requester i uses op[2i+1:2i].
- mask  input  WIDTH*NREQ  per-requester bit mask; requester i uses mask[WIDTH*i +: WIDTH].
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- busy  output  1  high whenever the FSM is not in IDLE.
- c_out  output  WIDTH  registered c lines to the bank.
- n_out  output  WIDTH  registered n lines to the bank.
- bank_q  input  WIDTH  bank outputs; used only when CNFF_CTRL_READBACK_EN is defined.
- err  output  1  readback mismatch flag; present only when CNFF_CTRL_READBACK_EN is defined.

Behaviour:
- Reset (async, rst_n=0) forces:
  - FSM to IDLE; ack=0, busy=0, c_out=0, n_out=0 (bank holds); err=0.
  - Round-robin pointer to 0, so requester 0 has highest priority first.
- Opcodes:
  - 00 NOP: completes with ack, no bank activity.
  - 01 CLR: clear masked bits.
  - 10 TGL: toggle masked bits.
  - 11 SET: CLR then TGL on masked bits, giving 1.
- IDLE:
  - If any req bit is high, pick the winner: first requester at or after the pointer, wrapping NREQ-1 to 0.
  - Latch winner index, op and mask. Go to EXEC1. No bank activity in this cycle.
- EXEC1: for the masked bits, drive n_out=mask.
  - CLR: c_out=0.
  - TGL: c_out=mask.
  - SET: c_out=0.
  - NOP: n_out=0.
  - Next state is EXEC2 for SET, otherwise ACK.
- EXEC2 (SET only): n_out=mask, c_out=mask. Next state is ACK.
- ACK:
  - c_out=0, n_out=0; ack[winner]=1 for exactly this cycle.
  - Pointer becomes (winner+1) mod NREQ. Next state is IDLE.
- Latency from req sampled high in IDLE to ack:
  - 3 cycles for NOP, CLR and TGL.
  - 4 cycles for SET.
- Requester protocol:
  - Hold req, op and mask stable until ack.
  - Deassert req in the cycle after ack, or keep it high to re-request; the pointer has already moved past this requester.
- Command capture:
  - Op and mask are latched at grant; later changes are ignored.
  - A req dropped mid-operation does not abort it, and ack is still issued.
- Simultaneous requests are served in round-robin order. With all NREQ requesters continuously requesting, each gets exactly one grant per NREQ grants.
- Mask bits that are 0 always see n_out=0 and c_out=0, so those cells hold.
- Mask=0 with CLR, TGL or SET behaves as NOP timing-wise, except SET still takes 4 cycles.
- Reset mid-operation: outputs clear immediately, the operation is lost, and no ack is issued. Bank contents are not restored.

Optional Feature:
- Macro: CNFF_CTRL_READBACK_EN.
- When defined:
  - The controller keeps a WIDTH-bit shadow copy of the bank, reset to 0 and updated with the same c/n semantics.
  - A CHECK state is inserted between EXEC and ACK, adding 1 cycle of latency.
  - In CHECK, if bank_q != shadow, err is set.
  - err is sticky until rst_n; ack is still issued.
- When undefined: the bank_q and err ports, the shadow register and the CHECK state are all absent, and latency is as listed above.

Decomposition:
- cnff_ctrl_pkg holds:
  - Opcode constants OP_NOP, OP_CLR, OP_TGL, OP_SET.
  - FSM state typedef: IDLE, EXEC1, EXEC2, CHECK, ACK.
  - The cnff next-state function, shared by the shadow model and the bench.
- One sub-module, rr_arbiter:
  - Parameter NREQ; inputs req and pointer; outputs a one-hot grant and its index.
  - Purely combinational; the pointer register stays in cnff_bank_ctrl.

Test Plan:
- Reset with bank=0; req[1]=1, op=TGL, mask=8'hA5 -> n_out=c_out=8'hA5 for one cycle, bank becomes 8'hA5, ack[1] pulses 3 cycles after req is sampled.
- Bank=8'hF0; req[2] SET with mask=8'h3C -> EXEC1 gives n=8'h3C, c=0, bank=8'hC0; EXEC2 gives c=8'h3C, bank=8'hFC; ack[2] at cycle 4.
- req=4'b1111 held continuously with CLR and distinct masks -> ack order 0,1,2,3,0 with no requester granted twice before all others.
- Pointer=2 (after a grant to requester 1); req=4'b1001 -> requester 3 is granted before requester 0.
- Assert rst_n=0 during EXEC2 of a SET -> c_out=n_out=0 and busy=0 immediately, no ack; next grant goes to requester 0.
- With CNFF_CTRL_READBACK_EN defined: force bank_q bit 0 stuck at 0, then TGL with mask=8'h01 -> err=1 in the cycle after CHECK, ack still issued, err stays high until reset.
